decoder_2x4_pulse: RTL

//  Receive end of the 4x2 priority-encoder path: takes a 2-bit code plus valid, expands it to a
//  one-hot 4-bit line, and drives that line as a timed pulse. Output is registered. A one-entry

---
 rtl/dec_pkg.sv | 24 ++
 rtl/dec_pulse_timer.sv | 38 +++
 rtl/decoder_2x4_pulse.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/dec_pkg.sv
// Shared types and helpers for the 2-to-4 pulse decoder.
//   state_e  : FSM states of decoder_2x4_pulse
//   LINE_N   : number of one-hot output lines
//   CODE_W   : width of the encoded line index
//   onehot4  : expands a 2-bit code to a 4-bit one-hot line
package dec_pkg;

    localparam int unsigned LINE_N = 4;
    localparam int unsigned CODE_W = 2;

    typedef enum logic [1:0] {
        StIdle,
        StPulse,
        StGap
    } state_e;

    function automatic logic [LINE_N-1:0] onehot4(input logic [CODE_W-1:0] code);
        logic [LINE_N-1:0] oh;
        oh       = '0;
        oh[code] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/dec_pulse_timer.sv
// Loadable down-counter with a zero flag; times both the PULSE and GAP phases.
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset (count cleared to 0)
//   load_i     : load load_val_i this cycle (wins over decrement)
//   load_val_i : value to load; the phase lasts load_val_i + 1 cycles
//   zero_o     : count is zero, i.e. the current cycle is the last of the phase
module dec_pulse_timer #(
    parameter int unsigned Width = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic             zero_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/decoder_2x4_pulse.sv
// 2-to-4 decoder that drives the selected line as a registered, timed pulse.
// A one-entry buffer lets the next code queue while a pulse or gap is running.
//   clk, rst_n : clock and asynchronous active-low reset
//   in_valid   : in_code valid; transfer on in_valid && in_ready
//   in_code    : encoded line index, 00 -> d_out[0] .. 11 -> d_out[3]
//   in_ready   : buffer not full (registered, no path from in_valid)
//   d_out      : registered one-hot pulse, zero when not pulsing
//   out_busy   : high while in PULSE or GAP
//   done       : one-cycle strobe in the cycle after the last PULSE cycle
//   hit_clr    : synchronous clear of all hit counters   (PULSE_COUNT_EN only)
//   hit_cnt    : {cnt3, cnt2, cnt1, cnt0} saturating     (PULSE_COUNT_EN only)
// Optional feature macro: PULSE_COUNT_EN adds the per-line hit counters.
module decoder_2x4_pulse
    import dec_pkg::*;
#(
    parameter int unsigned PULSE_LEN = 4,
    parameter int unsigned GAP_LEN   = 1,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [CODE_W-1:0]       in_code,
    output logic                    in_ready,
    output logic [LINE_N-1:0]       d_out,
    output logic                    out_busy,
`ifdef PULSE_COUNT_EN
    input  logic                    hit_clr,
    output logic [LINE_N*CNT_W-1:0] hit_cnt,
`endif
    output logic                    done
);

    localparam int unsigned MaxLen = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int unsigned TimerW = $clog2(MaxLen + 1);
    localparam bit          HasGap = (GAP_LEN > 0);
    localparam logic [TimerW-1:0] PulseLoad = TimerW'(PULSE_LEN - 1);
    localparam logic [TimerW-1:0] GapLoad   = TimerW'(HasGap ? GAP_LEN - 1 : 0);

    state_e              state_q, state_d;
    logic [LINE_N-1:0]   d_out_q, d_out_d;
    logic                buf_full_q, buf_full_d;
    logic [CODE_W-1:0]   buf_code_q, buf_code_d;
    logic                done_q, done_d;

    logic                xfer;
    logic                boundary;
    logic                start;
    logic [CODE_W-1:0]   start_code;
    logic                tmr_load;
    logic [TimerW-1:0]   tmr_val;
    logic                tmr_zero;

    dec_pulse_timer #(
        .Width (TimerW)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    assign xfer = in_valid && !buf_full_q;

    always_comb begin
        state_d    = state_q;
        d_out_d    = d_out_q;
        buf_full_d = buf_full_q;
        buf_code_d = buf_code_q;
        done_d     = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = PulseLoad;
        boundary   = 1'b0;
        start      = 1'b0;
        start_code = in_code;

        unique case (state_q)
            StIdle: begin
                start = xfer;
            end
            StPulse: begin
                if (tmr_zero) begin
                    done_d = 1'b1;
                    if (HasGap) begin
                        state_d  = StGap;
                        d_out_d  = '0;
                        tmr_load = 1'b1;
                        tmr_val  = GapLoad;
                    end else begin
                        boundary = 1'b1;
                    end
                end
            end
            StGap: begin
                boundary = tmr_zero;
            end
            default: begin
                state_d = StIdle;
                d_out_d = '0;
            end
        endcase

        // Buffered code has precedence; in_ready is low while it is held, so
        // a drain and a fill can never coincide.
        if (boundary) begin
            if (buf_full_q) begin
                start      = 1'b1;
                start_code = buf_code_q;
                buf_full_d = 1'b0;
            end else if (xfer) begin
                start = 1'b1;
            end else begin
                state_d = StIdle;
                d_out_d = '0;
            end
        end else if (xfer && (state_q != StIdle)) begin
            buf_full_d = 1'b1;
            buf_code_d = in_code;
        end

        if (start) begin
            state_d  = StPulse;
            d_out_d  = onehot4(start_code);
            tmr_load = 1'b1;
            tmr_val  = PulseLoad;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            d_out_q    <= '0;
            buf_full_q <= 1'b0;
            buf_code_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            d_out_q    <= d_out_d;
            buf_full_q <= buf_full_d;
            buf_code_q <= buf_code_d;
            done_q     <= done_d;
        end
    end

    assign in_ready = !buf_full_q;
    assign d_out    = d_out_q;
    assign out_busy = (state_q != StIdle);
    assign done     = done_q;

`ifdef PULSE_COUNT_EN
    logic [CNT_W-1:0] hit_q [LINE_N];
    logic [CNT_W-1:0] hit_d [LINE_N];

    always_comb begin
        for (int i = 0; i < LINE_N; i++) begin
            hit_d[i] = hit_q[i];
            if (hit_clr) begin
                hit_d[i] = '0;
            end else if (start && (start_code == CODE_W'(i)) && (hit_q[i] != '1)) begin
                hit_d[i] = hit_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LINE_N; i++) begin
                hit_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LINE_N; i++) begin
                hit_q[i] <= hit_d[i];
            end
        end
    end

    always_comb begin
        hit_cnt = '0;
        for (int i = 0; i < LINE_N; i++) begin
            hit_cnt[i*CNT_W +: CNT_W] = hit_q[i];
        end
    end
`endif

endmodule
